mem_access: RTL

- Memory stage of the pipeline. It sits directly downstream of the EX stage and consumes the EX result.
- For load/store ops, the EX result is the effective address. The block runs a req/ready handshake on the data RAM port, generates byte lanes, and sign/zero-extends load data.
- Non-memory ops pass through to writeback one cycle later.
- While a RAM access is pending, it holds the upstream stages via stall_req.

---
 rtl/mem_access_if.sv | 22 ++
 rtl/mem_access.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_if.sv
// Data RAM port of the memory stage: request/ready handshake with byte enables.
interface mem_access_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ram_req;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_addr;
  logic [3:0]            ram_sel;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_ready;

  modport master (
    output ram_req, ram_we, ram_addr, ram_sel, ram_wdata,
    input  ram_rdata, ram_ready
  );

  modport slave (
    input  ram_req, ram_we, ram_addr, ram_sel, ram_wdata,
    output ram_rdata, ram_ready
  );
endinterface

// File: rtl/mem_access.sv
// Memory pipeline stage: issues loads/stores on the data RAM port, extends load
// data, and forwards non-memory results to writeback one cycle later.
module mem_access #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  input  logic                      flush,
  input  logic                      mem_en,
  input  logic                      mem_write,
  input  logic [1:0]                mem_size,
  input  logic                      mem_signed,
  input  logic [DATA_WIDTH-1:0]     ex_result,
  input  logic [DATA_WIDTH-1:0]     store_data,
  input  logic                      reg_write_in,
  input  logic [REG_ADDR_WIDTH-1:0] dest_reg,
  output logic                      stall_req,
  output logic                      wb_valid,
  output logic                      wb_en,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      addr_error,
  output logic [DATA_WIDTH-1:0]     bad_addr,
  mem_access_if.master              ram
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                    state;
  logic [1:0]                size_q;
  logic                      signed_q;
  logic [1:0]                lane_q;
  logic [REG_ADDR_WIDTH-1:0] dest_q;
  logic                      rw_q;
  logic                      flushed_q;

  logic                      misaligned;
  logic                      accept;
  logic [3:0]                sel_c;
  logic [DATA_WIDTH-1:0]     wdata_c;
  logic [7:0]                byte_v;
  logic [15:0]               half_v;
  logic [DATA_WIDTH-1:0]     load_data;

  always_comb begin
    misaligned = 1'b0;
    sel_c      = '0;
    wdata_c    = '0;
    case (mem_size)
      2'b00: begin
        sel_c   = 4'b0001 << ex_result[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        misaligned = ex_result[0];
        sel_c      = ex_result[1] ? 4'b1100 : 4'b0011;
        wdata_c    = {2{store_data[15:0]}};
      end
      2'b10: begin
        misaligned = (ex_result[1:0] != 2'b00);
        sel_c      = 4'b1111;
        wdata_c    = store_data;
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign accept    = (state == IDLE) && ex_valid && !flush && mem_en && !misaligned;
  // Upstream must freeze in the accept cycle too, so the stall is combinational.
  assign stall_req = !rst && ((state == BUSY) || accept);

  always_comb begin
    byte_v = '0;
    case (lane_q)
      2'd0: byte_v = ram.ram_rdata[7:0];
      2'd1: byte_v = ram.ram_rdata[15:8];
      2'd2: byte_v = ram.ram_rdata[23:16];
      2'd3: byte_v = ram.ram_rdata[31:24];
      default: byte_v = '0;
    endcase
    half_v    = lane_q[1] ? ram.ram_rdata[31:16] : ram.ram_rdata[15:0];
    load_data = ram.ram_rdata;
    case (size_q)
      2'b00: load_data = {{24{signed_q & byte_v[7]}}, byte_v};
      2'b01: load_data = {{16{signed_q & half_v[15]}}, half_v};
      default: load_data = ram.ram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wb_valid      <= 1'b0;
      wb_en         <= 1'b0;
      wb_reg        <= '0;
      wb_data       <= '0;
      addr_error    <= 1'b0;
      bad_addr      <= '0;
      ram.ram_req   <= 1'b0;
      ram.ram_we    <= 1'b0;
      ram.ram_addr  <= '0;
      ram.ram_sel   <= '0;
      ram.ram_wdata <= '0;
      size_q        <= '0;
      signed_q      <= 1'b0;
      lane_q        <= '0;
      dest_q        <= '0;
      rw_q          <= 1'b0;
      flushed_q     <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      addr_error <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid && !flush) begin
            if (!mem_en) begin
              wb_valid <= 1'b1;
              wb_en    <= reg_write_in;
              wb_reg   <= dest_reg;
              wb_data  <= ex_result;
            end else if (misaligned) begin
              addr_error <= 1'b1;
              bad_addr   <= ex_result;
              wb_valid   <= 1'b1;
              wb_en      <= 1'b0;
            end else begin
              ram.ram_req   <= 1'b1;
              ram.ram_we    <= mem_write;
              ram.ram_addr  <= {ex_result[DATA_WIDTH-1:2], 2'b00};
              ram.ram_sel   <= sel_c;
              ram.ram_wdata <= wdata_c;
              size_q        <= mem_size;
              signed_q      <= mem_signed;
              lane_q        <= ex_result[1:0];
              dest_q        <= dest_reg;
              rw_q          <= reg_write_in;
              flushed_q     <= 1'b0;
              state         <= BUSY;
            end
          end
        end
        BUSY: begin
          if (flush) flushed_q <= 1'b1;
          if (ram.ram_ready) begin
            ram.ram_req   <= 1'b0;
            ram.ram_we    <= 1'b0;
            ram.ram_addr  <= '0;
            ram.ram_sel   <= '0;
            ram.ram_wdata <= '0;
            state         <= IDLE;
            // A flush seen at any point of the access, including this cycle, kills the writeback.
            if (!flushed_q && !flush) begin
              wb_valid <= 1'b1;
              wb_reg   <= dest_q;
              if (ram.ram_we) begin
                wb_en   <= 1'b0;
                wb_data <= '0;
              end else begin
                wb_en   <= rw_q;
                wb_data <= load_data;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
